t_counter_ctrl: RTL
===================

T_COUNTER_CTRL -- requirements
Module: t_counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, number of T flip-flops in the controlled bank (counter width).
REQ-002 Port: Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high; clears all state immediately, independent of Clk.
REQ-004 Port: Start  input  1  begin a count from IDLE, or resume from PAUSE.
REQ-005 Port: Stop  input  1  pause from RUN; abort to IDLE from PAUSE.
REQ-006 Port: Up  input  1  direction (1 = up, 0 = down); sampled only on an accepted Start from IDLE.
REQ-007 Port: OneShot  input  1  1 = finish at terminal count; 0 = wrap and continue; sampled only on an accepted Start from IDLE.
REQ-008 Port: Limit  input  WIDTH  modulo limit (count range 0..Limit); sampled only on an accepted Start from IDLE.
REQ-009 Port: Tog  output  WIDTH  combinational toggle vector; bit i = 1 means flip-flop i toggles at the next Clk edge.
REQ-010 Port: Q  output  WIDTH  current T flip-flop bank state (the count).
REQ-011 Port: Qnot  output  WIDTH  bitwise complement of Q, always.
REQ-012 Port: Busy  output  1  high in RUN and PAUSE.
REQ-013 Port: Wrap  output  1  one-cycle pulse, high in the cycle Tog applies a terminal-count wrap.
REQ-014 Port: Done  output  1  one-cycle pulse, high for the single cycle in DONE.

Function
REQ-015 Internal bank SHALL be WIDTH T flip-flops: every edge, Q <= Q ^ Tog; Q SHALL change by no other path.
REQ-016 Latched registers LimR, UpR, OneR SHALL capture Limit, Up, OneShot on an accepted Start in IDLE and hold otherwise.
REQ-017 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-018 IDLE: Tog = Q ^ 0 (drives bank to 0, then Tog = 0); Start -> RUN, Tog = Q ^ S where S = 0 if Up else Limit (load via toggles).
REQ-019 RUN: next N = (Q == LimR) ? 0 : Q+1 when UpR; N = (Q == 0) ? LimR : Q-1 when !UpR; Tog = Q ^ N.
REQ-020 RUN terminal (Q == LimR up, Q == 0 down): OneR = 0 -> Wrap = 1, apply N, stay RUN; OneR = 1 -> Tog = 0, Wrap = 0, go DONE.
REQ-021 RUN with Stop = 1 -> PAUSE, Tog = 0 that cycle; Stop has priority over terminal handling and over Start.
REQ-022 PAUSE: Tog = 0, Q held; Stop -> IDLE; else Start -> RUN (no reload, latched config kept).
REQ-023 DONE: Done = 1, Tog = 0, Q holds terminal value; unconditionally -> IDLE next cycle; Start/Stop ignored.
REQ-024 Start and Stop both high: Stop wins in every state (IDLE: no-op, stays IDLE).
REQ-025 Limit = 0: up or down, Q stays 0; OneR = 0 -> Wrap every RUN cycle; OneR = 1 -> DONE after one RUN cycle.
REQ-026 Arithmetic modulo 2^WIDTH; Limit = all-ones gives full-range count with no special case.
REQ-027 Limit/Up/OneShot changes while Busy SHALL have no effect.
REQ-028 Wrap and Done SHALL never be high in the same cycle; Busy = 0 in IDLE and DONE.

Reset
REQ-029 Reset high SHALL immediately force: state IDLE, Q = 0, Qnot = all-ones, LimR = 0, UpR = 1, OneR = 0, Busy = 0, Wrap = 0, Done = 0, Tog = 0.
REQ-030 Reset asserted mid-RUN/PAUSE/DONE SHALL abort without Done or Wrap pulse; Start is ignored while Reset is high.
REQ-031 After release, first accepted Start SHALL behave as from power-up.

Verification (WIDTH = 4)
REQ-032 Up wrap: Limit = 5, Up = 1, OneShot = 0, Start pulse -> Q = 0,1,2,3,4,5,0,1...; Wrap high in the cycle Q = 5; Tog = 0001,0011,0001,0111,0001,0101 across the first cycles.
REQ-033 Down one-shot: Limit = 3, Up = 0, OneShot = 1 -> Q = 3,2,1,0, one DONE cycle with Done = 1 and Q = 0, then IDLE, Busy low.
REQ-034 Pause/resume: Limit = 15 up, Stop at Q = 6 -> Q holds 6, Tog = 0 for 5 cycles; Start -> continues 7,8...; Stop in PAUSE -> IDLE, Q returns to 0.
REQ-035 Priority/edge: Start + Stop together in IDLE -> stays IDLE; Limit = 0 with OneShot = 0 -> Q = 0, Wrap high every RUN cycle.
REQ-036 Async reset: Reset asserted between edges at Q = 9 -> Q = 0, Qnot = 1111, Busy = 0 before next Clk edge; no Done pulse.
REQ-037 All scenarios: check Qnot == ~Q and Q(next) == Q ^ Tog every cycle.

Source files
------------

// File: rtl/t_counter_ctrl.sv
// t_counter_ctrl
//   Controller for a bank of WIDTH T flip-flops that form an up/down modulo
//   counter. The controller never loads the bank directly: every rising edge
//   the bank does Q <= Q ^ Tog, and all counting, loading and clearing is
//   expressed through the combinational toggle vector Tog.
//
//   Ports
//     Clk      in   clock, rising edge
//     Reset    in   asynchronous active-high reset
//     Start    in   begin count from IDLE / resume from PAUSE
//     Stop     in   pause from RUN / abort to IDLE from PAUSE (wins over Start)
//     Up       in   count direction, latched on an accepted Start in IDLE
//     OneShot  in   1 = stop at terminal count, latched with Up
//     Limit    in   modulo limit (count range 0..Limit), latched with Up
//     Tog      out  toggle vector applied to the bank at the next edge
//     Q        out  bank state (the count)
//     Qnot     out  bitwise complement of Q
//     Busy     out  high in RUN and PAUSE
//     Wrap     out  high in the cycle Tog applies a terminal-count wrap
//     Done     out  high for the single cycle spent in DONE
module t_counter_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Up,
   input  logic             OneShot,
   input  logic [WIDTH-1:0] Limit,
   output logic [WIDTH-1:0] Tog,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qnot,
   output logic             Busy,
   output logic             Wrap,
   output logic             Done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] lim_q;
   logic             up_q;
   logic             one_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] tog_d;
   logic             wrap_d;
   logic [WIDTH-1:0] next_cnt;
   logic             term;

   // Modulo successor of the count in the latched direction.
   function automatic logic [WIDTH-1:0] next_count(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] lim,
      input logic             up
   );
      logic [WIDTH-1:0] r;
      if (up) r = (cur == lim)  ? '0  : cur + WIDTH'(1);
      else    r = (cur == '0)   ? lim : cur - WIDTH'(1);
      return r;
   endfunction

   // Next state and toggle vector
   always_comb begin
      state_d  = state_q;
      tog_d    = '0;
      wrap_d   = 1'b0;
      next_cnt = next_count(q_q, lim_q, up_q);
      term     = up_q ? (q_q == lim_q) : (q_q == '0);
      case (state_q)
         IDLE: begin
            // Idle toggles drive the bank back to zero; an accepted Start
            // instead loads the start value (0 up, Limit down) in one edge.
            tog_d = q_q;
            if (Start && !Stop) begin
               state_d = RUN;
               tog_d   = q_q ^ (Up ? '0 : Limit);
            end
         end
         RUN: begin
            if (Stop) begin
               state_d = PAUSE;
            end else if (term && one_q) begin
               state_d = DONE;
            end else begin
               tog_d  = q_q ^ next_cnt;
               wrap_d = term;
            end
         end
         PAUSE: begin
            if (Stop)       state_d = IDLE;
            else if (Start) state_d = RUN;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset forces the toggle and wrap outputs low immediately, so nothing
   // reaches the bank while Reset is high.
   assign Tog  = Reset ? '0 : tog_d;
   assign Wrap = !Reset && wrap_d;
   assign Q    = q_q;
   assign Qnot = ~q_q;
   assign Busy = busy_q;
   assign Done = done_q;

   // State, T flip-flop bank, latched configuration and registered flags
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         lim_q   <= '0;
         up_q    <= 1'b1;
         one_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_q ^ Tog;
         busy_q  <= (state_d == RUN) || (state_d == PAUSE);
         done_q  <= (state_d == DONE);
         if (state_q == IDLE && Start && !Stop) begin
            lim_q <= Limit;
            up_q  <= Up;
            one_q <= OneShot;
         end
      end
   end

endmodule
